// File: rtl/cla_32bit.sv
// cla_32bit: registered 32-bit adder built on a two-level carry-lookahead tree.
//
// {cout, sum} = A + B + cin, computed to 33 bits and registered on the rising
// CLK edge. Latency is one cycle by default.
//
// Build option:
//   CLA_INPUT_REG_EN - when defined, A, B and cin are first captured in input
//                      registers, which makes the latency two cycles. The
//                      arithmetic result is the same either way.
//
// Ports:
//   CLK     in   1   rising-edge clock
//   RESETn  in   1   asynchronous active-low reset; clears every register
//   A       in  32   addend A (unsigned)
//   B       in  32   addend B (unsigned)
//   cin     in   1   carry-in
//   sum     out 32   registered sum bits [31:0]
//   cout    out  1   registered carry-out from bit 31

module cla_32bit (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    // Adder operands: either the raw ports or their registered copies.
    logic [31:0] a_op;
    logic [31:0] b_op;
    logic        cin_op;

`ifdef CLA_INPUT_REG_EN
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            a_op   <= '0;
            b_op   <= '0;
            cin_op <= 1'b0;
        end else begin
            a_op   <= A;
            b_op   <= B;
            cin_op <= cin;
        end
    end
`else
    assign a_op   = A;
    assign b_op   = B;
    assign cin_op = cin;
`endif

    // Bit-level generate / propagate.
    logic [31:0] g;
    logic [31:0] p;

    assign g = a_op & b_op;
    assign p = a_op ^ b_op;

    // Group generate / propagate for the eight 4-bit groups.
    logic [7:0] grp_g;
    logic [7:0] grp_p;

    // c_grp[k] is the carry into group k (bit 4k); c_grp[0] is cin.
    logic [7:0]  c_grp;
    // Carry into every bit position.
    logic [31:0] c;

    logic [31:0] sum_next;
    logic        cout_next;

    genvar k, j;

    generate
        for (k = 0; k < 8; k++) begin : g_grp
            assign grp_g[k] = g[4*k+3]
                            | (p[4*k+3] & g[4*k+2])
                            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            assign grp_p[k] = &p[4*k+3 : 4*k];
        end
    endgenerate

    assign c_grp[0] = cin_op;

    // Second-level lookahead: each group carry is a single sum of products
    // over group G/P and cin, so no carry passes from one group to the next.
    // term[0] is cin propagated through groups 0..k-1; term[j] (j >= 1) is
    // G[j-1] propagated through groups j..k-1.
    generate
        for (k = 1; k < 8; k++) begin : g_lvl2
            logic [k:0] term;
            assign term[0] = cin_op & (&grp_p[k-1:0]);
            for (j = 1; j <= k; j++) begin : g_term
                if (j == k) begin : g_last
                    assign term[j] = grp_g[k-1];
                end else begin : g_mid
                    assign term[j] = grp_g[j-1] & (&grp_p[k-1:j]);
                end
            end
            assign c_grp[k] = |term;
        end
    endgenerate

    // Intra-group lookahead carries, each from the group's carry-in.
    generate
        for (k = 0; k < 8; k++) begin : g_int
            assign c[4*k]   = c_grp[k];
            assign c[4*k+1] = g[4*k]
                            | (p[4*k] & c_grp[k]);
            assign c[4*k+2] = g[4*k+1]
                            | (p[4*k+1] & g[4*k])
                            | (p[4*k+1] & p[4*k] & c_grp[k]);
            assign c[4*k+3] = g[4*k+2]
                            | (p[4*k+2] & g[4*k+1])
                            | (p[4*k+2] & p[4*k+1] & g[4*k])
                            | (p[4*k+2] & p[4*k+1] & p[4*k] & c_grp[k]);
        end
    endgenerate

    assign sum_next  = p ^ c;
    assign cout_next = grp_g[7] | (grp_p[7] & c_grp[7]);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_next;
            cout <= cout_next;
        end
    end

endmodule

// File: tb/tb_cla_32bit.sv
// tb_cla_32bit: scoreboard bench for cla_32bit.
//
// The driver applies operands on the falling edge and pushes the 33-bit
// reference result into a queue. A bench-side flag pipeline of the DUT's
// latency marks which rising edges present a checked result; the monitor
// pops and compares just after those edges. Extra checks cover the
// asynchronous reset and that mid-cycle input changes do not reach the outputs.
//
// Define CLA_INPUT_REG_EN for both bench and RTL to exercise two-cycle latency.

module tb_cla_32bit;

`ifdef CLA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        CLK;
    logic        RESETn;
    logic [31:0] A;
    logic [31:0] B;
    logic        cin;
    logic [31:0] sum;
    logic        cout;

    cla_32bit dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .A      (A),
        .B      (B),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [32:0] exp_q[$];
    logic        pend;
    logic [1:0]  pipe;
    logic [32:0] mon_exp;
    logic [32:0] last_exp;
    bit          have_last;

    // Reference: plain 33-bit unsigned addition.
    function automatic logic [32:0] ref_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        c);
        return {1'b0, a} + {1'b0, b} + {32'b0, c};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic c, input bit check);
        @(negedge CLK);
        A    = a;
        B    = b;
        cin  = c;
        pend = check;
        if (check) exp_q.push_back(ref_add(a, b, c));
    endtask

    // Tracks which edges present a checked result; a reset discards in-flight work.
    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) pipe <= '0;
        else         pipe <= {pipe[0], pend};
    end

    // Monitor: compare just after each rising edge that presents a result.
    always @(posedge CLK) begin
        #1;
        if (RESETn && pipe[LAT-1]) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow: got {cout,sum}=%h, required a queued expectation", {cout, sum});
                have_last = 0;
            end else begin
                mon_exp = exp_q.pop_front();
                if ({cout, sum} !== mon_exp) begin
                    n_bad++;
                    $display("FAIL result: got {cout,sum}=%h, required %h", {cout, sum}, mon_exp);
                end
                last_exp  = mon_exp;
                have_last = 1;
            end
        end else begin
            have_last = 0;
        end
    end

    // Mid-cycle: inputs changed at the falling edge must not reach the outputs.
    always @(negedge CLK) begin
        #3;
        if (RESETn && have_last) begin
            n_cmp++;
            if ({cout, sum} !== last_exp) begin
                n_bad++;
                $display("FAIL hold: got {cout,sum}=%h mid-cycle, required %h", {cout, sum}, last_exp);
            end
        end
        if (!RESETn) have_last = 0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESETn = 1'b0;
        A      = '0;
        B      = '0;
        cin    = 1'b0;
        pend   = 1'b0;
        have_last = 0;

        #12;
        n_cmp++;
        if ({cout, sum} !== 33'h0) begin
            n_bad++;
            $display("FAIL reset_init: got {cout,sum}=%h, required 0", {cout, sum});
        end
        @(negedge CLK);
        RESETn = 1'b1;

        // Reset pulsed between edges while the adder holds a nonzero result.
        repeat (3) issue(32'h12345678, 32'h1, 1'b1, 0);
        @(negedge CLK);
        #2 RESETn = 1'b0;
        #1;
        n_cmp++;
        if ({cout, sum} !== 33'h0) begin
            n_bad++;
            $display("FAIL reset_async: got {cout,sum}=%h, required 0", {cout, sum});
        end
        #1 RESETn = 1'b1;
        pend = 1'b1;
        exp_q.push_back(ref_add(A, B, cin));

        // Directed boundary cases.
        issue(32'h00000001, 32'h00000002, 1'b0, 1);
        issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 1);
        issue(32'h0000FFFF, 32'h00000000, 1'b1, 1);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1);
        issue(32'h0FFFFFFF, 32'h00000000, 1'b1, 1);
        issue(32'h80000000, 32'h80000000, 1'b0, 1);

        // Streaming sweep: back-to-back results, one per cycle.
        for (int unsigned i = 0; i < 32; i++)
            issue(i, 2 * i, 1'b0, 1);

        // Randomized vectors, with carry-heavy patterns mixed in.
        for (int unsigned i = 0; i < 10000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if ((i % 8) == 0) rb = ~ra;
            issue(ra, rb, 1'($urandom_range(0, 1)), 1);
        end

        // Drain the pipeline.
        repeat (LAT + 3) issue(32'h0, 32'h0, 1'b0, 0);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d results still queued, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
